// File: rtl/rggen_address_decoder_array.sv
// Multi-register access controller: decodes a host command against a table of address windows,
// drives a registered one-hot select, waits for done (or timeout) and returns a status/data response.
module rggen_address_decoder_array #(
  parameter int unsigned REGISTERS          = 4,
  parameter int unsigned ADDRESS_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned SHADOW_INDEX_WIDTH = 1,
  parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]      START_ADDRESSES     = '0,
  parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]      END_ADDRESSES       = '0,
  parameter logic [REGISTERS-1:0]                    READABLE            = '1,
  parameter logic [REGISTERS-1:0]                    WRITABLE            = '1,
  parameter logic [REGISTERS-1:0]                    USE_SHADOW_INDEX    = '0,
  parameter logic [REGISTERS*SHADOW_INDEX_WIDTH-1:0] SHADOW_INDEX_VALUES = '0,
  parameter int unsigned TIMEOUT_CYCLES     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_command_valid,
  output logic                              o_command_ready,
  input  logic                              i_write,
  input  logic [ADDRESS_WIDTH-1:0]          i_address,
  input  logic [SHADOW_INDEX_WIDTH-1:0]     i_shadow_index,
  output logic [REGISTERS-1:0]              o_select,
  output logic                              o_write,
  input  logic [REGISTERS-1:0]              i_register_done,
  input  logic [REGISTERS*DATA_WIDTH-1:0]   i_register_read_data,
  output logic                              o_response_valid,
  input  logic                              i_response_ready,
  output logic [1:0]                        o_response_status,
  output logic [DATA_WIDTH-1:0]             o_read_data
);

  localparam int unsigned TimerWidth =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerWidth-1:0] TimeoutValue = TimerWidth'(TIMEOUT_CYCLES);

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusError   = 2'b10;
  localparam logic [1:0] StatusTimeout = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond
  } state_e;

  state_e                  state_q, state_d;
  logic [REGISTERS-1:0]    select_q, select_d;
  logic                    write_q, write_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic [1:0]              status_q, status_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [REGISTERS-1:0]    hit;
  logic [REGISTERS-1:0]    winner;
  logic                    found;
  logic                    permitted;
  logic                    selected_done;
  logic [DATA_WIDTH-1:0]   selected_data;

  // Window match, then keep only the lowest hitting entry so overlaps resolve by index.
  always_comb begin
    hit    = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < REGISTERS; i++) begin
      hit[i] = (i_address >= START_ADDRESSES[i*ADDRESS_WIDTH+:ADDRESS_WIDTH]) &&
               (i_address <= END_ADDRESSES[i*ADDRESS_WIDTH+:ADDRESS_WIDTH]) &&
               (!USE_SHADOW_INDEX[i] ||
                (i_shadow_index == SHADOW_INDEX_VALUES[i*SHADOW_INDEX_WIDTH+:SHADOW_INDEX_WIDTH]));
      if (hit[i] && !found) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
    permitted = |(winner & (i_write ? WRITABLE : READABLE));
  end

  always_comb begin
    selected_data = '0;
    for (int unsigned i = 0; i < REGISTERS; i++) begin
      if (select_q[i]) begin
        selected_data = selected_data | i_register_read_data[i*DATA_WIDTH+:DATA_WIDTH];
      end
    end
    selected_done = |(i_register_done & select_q);
  end

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    write_d  = write_q;
    timer_d  = timer_q;
    status_d = status_q;
    data_d   = data_q;
    unique case (state_q)
      StIdle: begin
        if (i_command_valid) begin
          if (found && permitted) begin
            state_d  = StAccess;
            select_d = winner;
            write_d  = i_write;
            timer_d  = TimerWidth'(1);
          end else begin
            state_d  = StRespond;
            status_d = StatusError;
            data_d   = '0;
          end
        end
      end
      StAccess: begin
        // Done takes priority over a timeout expiring in the same cycle.
        if (selected_done) begin
          state_d  = StRespond;
          status_d = StatusOk;
          data_d   = write_q ? '0 : selected_data;
          select_d = '0;
          write_d  = 1'b0;
          timer_d  = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TimeoutValue)) begin
          state_d  = StRespond;
          status_d = StatusTimeout;
          data_d   = '0;
          select_d = '0;
          write_d  = 1'b0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end
      StRespond: begin
        if (i_response_ready) begin
          state_d  = StIdle;
          status_d = StatusOk;
          data_d   = '0;
          timer_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      select_q <= '0;
      write_q  <= 1'b0;
      timer_q  <= '0;
      status_q <= StatusOk;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      write_q  <= write_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      data_q   <= data_d;
    end
  end

  assign o_command_ready   = (state_q == StIdle);
  assign o_select          = select_q;
  assign o_write           = write_q;
  assign o_response_valid  = (state_q == StRespond);
  assign o_response_status = status_q;
  assign o_read_data       = data_q;

endmodule
